// File: rtl/mvau_weight_loader.sv
// Runtime weight-memory writer for one MVAU PE.
// Takes one AXI-Stream weight set, writes it word by word into the PE weight
// memory through a registered write port, and pulses load_done together with
// the final write so the MVAU control can start reading immediately after.
module mvau_weight_loader #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    load_start,
  input  logic [SIMD*TW-1:0]      s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic                    wmem_we,
  output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
  output logic [SIMD*TW-1:0]      wmem_wdata,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_err
);

  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t                  state;
  logic [WMEM_ADDR_BW-1:0] cnt;
  logic                    accept;
  logic                    is_final;

  // tready is a registered copy of "in LOAD", so a handshake implies LOAD
  assign accept   = s_axis_tvalid & s_axis_tready;
  assign is_final = (cnt == LAST_ADDR);

  // Load sequencer: word counter, handshake/status outputs and framing check
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      s_axis_tready <= 1'b0;
      load_busy     <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            state         <= S_LOAD;
            cnt           <= '0;
            load_err      <= 1'b0;
            s_axis_tready <= 1'b1;
            load_busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (is_final || s_axis_tlast) begin
              // Final word, or an early tlast that truncates the set.
              // The counter stays put so it never passes the last address.
              state         <= S_DONE;
              s_axis_tready <= 1'b0;
              load_busy     <= 1'b0;
              load_done     <= 1'b1;
              if (is_final != s_axis_tlast) begin
                load_err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          // load_done is high for exactly this one cycle
          state <= S_IDLE;
        end
        default: begin
          state         <= S_IDLE;
          s_axis_tready <= 1'b0;
          load_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Write port stage: each accepted beat lands in memory one cycle later
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wmem_we    <= 1'b0;
      wmem_waddr <= '0;
      wmem_wdata <= '0;
    end else begin
      wmem_we <= accept;
      if (accept) begin
        wmem_waddr <= cnt;
        wmem_wdata <= s_axis_tdata;
      end
    end
  end

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Bench for mvau_weight_loader: directed load scenarios, a per-cycle reference
// model of the loader, and literal checks on the memory image each load leaves.
module tb_mvau_weight_loader;

  localparam int SIMD = 2;
  localparam int TW   = 1;
  localparam int D    = 4;
  localparam int AW   = 4;
  localparam int W    = SIMD * TW;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          load_start = 1'b0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          wmem_we;
  logic [AW-1:0] wmem_waddr;
  logic [W-1:0]  wmem_wdata;
  logic          load_busy;
  logic          load_done;
  logic          load_err;

  int checks = 0;
  int failures = 0;

  mvau_weight_loader #(
    .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(D), .WMEM_ADDR_BW(AW)
  ) dut (
    .aclk(aclk), .areset(areset), .load_start(load_start),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .wmem_we(wmem_we), .wmem_waddr(wmem_waddr), .wmem_wdata(wmem_wdata),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting for a start, 1 = taking words, 2 = done cycle
  int           m_phase = 0;
  int           m_n = 0;
  logic         m_err = 1'b0;
  logic         m_we = 1'b0;
  int           m_addr = 0;
  logic [W-1:0] m_data = '0;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_phase <= 0; m_n <= 0; m_err <= 1'b0;
      m_we <= 1'b0; m_addr <= 0; m_data <= '0;
    end else begin
      m_we <= 1'b0;
      if (m_phase == 0) begin
        if (load_start) begin
          m_phase <= 1; m_n <= 0; m_err <= 1'b0;
        end
      end else if (m_phase == 1) begin
        if (s_axis_tvalid) begin
          m_we   <= 1'b1;
          m_addr <= m_n;
          m_data <= s_axis_tdata;
          if (m_n == D - 1) begin
            m_phase <= 2;
            if (!s_axis_tlast) m_err <= 1'b1;
          end else if (s_axis_tlast) begin
            m_phase <= 2;
            m_err   <= 1'b1;
          end else begin
            m_n <= m_n + 1;
          end
        end
      end else begin
        m_phase <= 0;
      end
    end
  end

  // Observed memory image and event counts, cleared whenever seq changes
  logic [W-1:0] mem [D];
  logic [D-1:0] mask;
  int           nwr, ndone, first_addr, seq = 0, seen_seq = -1;
  logic         done_we;
  int           done_addr;

  // Compare DUT against the model every cycle and record what was written
  always @(negedge aclk) begin
    if (seq != seen_seq) begin
      seen_seq = seq; mask = '0; nwr = 0; ndone = 0; first_addr = -1;
      done_we = 1'b0; done_addr = -1;
    end
    check("tready", {31'd0, s_axis_tready}, {31'd0, m_phase == 1});
    check("busy",   {31'd0, load_busy},     {31'd0, m_phase == 1});
    check("done",   {31'd0, load_done},     {31'd0, m_phase == 2});
    check("err",    {31'd0, load_err},      {31'd0, m_err});
    check("we",     {31'd0, wmem_we},       {31'd0, m_we});
    check("waddr",  32'(wmem_waddr),        32'(m_addr));
    check("wdata",  32'(wmem_wdata),        32'(m_data));
    if (wmem_we && !areset) begin
      if (wmem_waddr < AW'(D)) begin
        mem[wmem_waddr[1:0]] = wmem_wdata;
        mask[wmem_waddr[1:0]] = 1'b1;
      end
      if (nwr == 0) first_addr = int'(wmem_waddr);
      nwr++;
    end
    if (load_done) begin
      ndone++;
      done_we = wmem_we;
      done_addr = int'(wmem_waddr);
    end
  end

  task automatic cyc();
    @(negedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic start();
    seq++;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
  endtask

  task automatic beat(input logic [W-1:0] d, input logic last);
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = last;
    cyc();
  endtask

  task automatic check_image(input string tag, input logic [4*W-1:0] img);
    for (int a = 0; a < D; a++) begin
      check({tag, "_mem"}, 32'(mem[a]), 32'(img[a*W +: W]));
    end
  endtask

  initial begin
    // Reset state
    cyc();
    check("rst_we", {31'd0, wmem_we}, 32'd0);
    check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    check("rst_err", {31'd0, load_err}, 32'd0);
    areset = 1'b0;
    idle(2);

    // Nominal: 1,2,3,0 back to back, tlast on the fourth
    start();
    beat(2'h1, 1'b0); beat(2'h2, 1'b0); beat(2'h3, 1'b0); beat(2'h0, 1'b1);
    check("nom_tready_drop", {31'd0, s_axis_tready}, 32'd0);
    idle(3);
    check_image("nom", {2'h0, 2'h3, 2'h2, 2'h1});
    check("nom_nwr", nwr, 4);
    check("nom_ndone", ndone, 1);
    check("nom_done_we", {31'd0, done_we}, 32'd1);
    check("nom_done_addr", done_addr, 3);
    check("nom_err", {31'd0, load_err}, 32'd0);

    // Throttled: tvalid 1,0,0,1,0,0,... data 3,2,1,0
    start();
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) beat(2'(3 - i / 3), i == 9);
      else begin s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; cyc(); end
    end
    idle(3);
    check_image("thr", {2'h0, 2'h1, 2'h2, 2'h3});
    check("thr_nwr", nwr, 4);
    check("thr_ndone", ndone, 1);

    // Early tlast on the second word
    start();
    beat(2'h2, 1'b0); beat(2'h1, 1'b1);
    idle(4);
    check("early_mask", 32'(mask), 32'h3);
    check("early_nwr", nwr, 2);
    check("early_ndone", ndone, 1);
    check("early_done_addr", done_addr, 1);
    check("early_err_sticky", {31'd0, load_err}, 32'd1);
    start();
    check("early_err_clear", {31'd0, load_err}, 32'd0);
    beat(2'h0, 1'b0); beat(2'h1, 1'b0); beat(2'h2, 1'b0); beat(2'h3, 1'b1);
    idle(3);
    check_image("reload", {2'h3, 2'h2, 2'h1, 2'h0});
    check("reload_first", first_addr, 0);
    check("reload_err", {31'd0, load_err}, 32'd0);

    // Missing tlast on the final word
    start();
    beat(2'h3, 1'b0); beat(2'h3, 1'b0); beat(2'h2, 1'b0); beat(2'h2, 1'b0);
    idle(3);
    check("miss_nwr", nwr, 4);
    check("miss_ndone", ndone, 1);
    check("miss_err", {31'd0, load_err}, 32'd1);

    // Reset after two words: outputs clear before the next clock edge
    start();
    beat(2'h1, 1'b0); beat(2'h2, 1'b0);
    s_axis_tvalid = 1'b0;
    #1 areset = 1'b1;
    #1;
    check("arst_we", {31'd0, wmem_we}, 32'd0);
    check("arst_waddr", 32'(wmem_waddr), 32'd0);
    check("arst_wdata", 32'(wmem_wdata), 32'd0);
    check("arst_tready", {31'd0, s_axis_tready}, 32'd0);
    check("arst_busy", {31'd0, load_busy}, 32'd0);
    check("arst_err", {31'd0, load_err}, 32'd0);
    cyc(); cyc();
    areset = 1'b0;
    idle(2);
    check("arst_ndone", ndone, 0);
    start();
    beat(2'h3, 1'b0); beat(2'h0, 1'b0); beat(2'h1, 1'b0); beat(2'h2, 1'b1);
    idle(3);
    check("arst_first", first_addr, 0);
    check_image("arst", {2'h2, 2'h1, 2'h0, 2'h3});

    // Stream offered while idle, then load_start pulsed in the middle of a load
    seq++;
    for (int i = 0; i < 3; i++) beat(2'h3, 1'b1);
    idle(1);
    check("idle_nwr", nwr, 0);
    start();
    beat(2'h1, 1'b0); beat(2'h1, 1'b0);
    load_start = 1'b1;
    beat(2'h2, 1'b0);
    load_start = 1'b0;
    beat(2'h3, 1'b1);
    idle(3);
    check_image("midst", {2'h3, 2'h2, 2'h1, 2'h1});
    check("midst_nwr", nwr, 4);
    check("midst_ndone", ndone, 1);
    check("midst_err", {31'd0, load_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
